// File: rtl/mouse_init_sequencer_pkg.sv
// Shared constants, state encoding and ROM entry type for the PS/2 mouse
// initialisation sequencer.
package mouse_init_sequencer_pkg;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_SET_RATE = 8'hF3;
    localparam logic [7:0] CMD_GET_ID   = 8'hF2;

    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;
    localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
    localparam logic [7:0] RSP_ERR      = 8'hFC;
    localparam logic [7:0] ID_WHEEL     = 8'h03;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_TX,
        ST_WAIT_ACK,
        ST_WAIT_BAT,
        ST_WAIT_ID,
        ST_STREAM,
        ST_FAIL
    } state_t;

    typedef struct packed {
        logic [7:0] cmd;
        logic       expect_id;
        logic       last;
    } rom_entry_t;

    function automatic logic is_wait(state_t s);
        return (s == ST_WAIT_TX) || (s == ST_WAIT_ACK) ||
               (s == ST_WAIT_BAT) || (s == ST_WAIT_ID);
    endfunction

endpackage

// File: rtl/mouse_init_sequencer_cmd_rom.sv
// Step index to command byte lookup. Contents depend on MOUSE_SEQ_WHEEL_EN:
// defined adds the wheel-unlock rate sequence and GET_ID before enabling.
import mouse_init_sequencer_pkg::*;

module mouse_cmd_rom (
    input  logic [3:0] step,
    output rom_entry_t entry
);

    // Pure lookup; out-of-range steps fall back to the enable command
    always_comb begin
        entry = '{cmd: CMD_ENABLE, expect_id: 1'b0, last: 1'b1};
`ifdef MOUSE_SEQ_WHEEL_EN
        unique case (step)
            4'd0: entry = '{CMD_RESET,    1'b0, 1'b0};
            4'd1: entry = '{CMD_SET_RATE, 1'b0, 1'b0};
            4'd2: entry = '{8'hC8,        1'b0, 1'b0};
            4'd3: entry = '{CMD_SET_RATE, 1'b0, 1'b0};
            4'd4: entry = '{8'h64,        1'b0, 1'b0};
            4'd5: entry = '{CMD_SET_RATE, 1'b0, 1'b0};
            4'd6: entry = '{8'h50,        1'b0, 1'b0};
            4'd7: entry = '{CMD_GET_ID,   1'b1, 1'b0};
            default: entry = '{CMD_ENABLE, 1'b0, 1'b1};
        endcase
`else
        if (step == 4'd0) begin
            entry = '{CMD_RESET, 1'b0, 1'b0};
        end
`endif
    end

endmodule

// File: rtl/mouse_init_sequencer.sv
// PS/2 mouse power-up sequencer: sends commands, checks replies, retries,
// then enables stream mode. Wheel detection enabled by MOUSE_SEQ_WHEEL_EN.
import mouse_init_sequencer_pkg::*;

module mouse_init_sequencer #(
    parameter int RESP_TIMEOUT = 2_500_000,
    parameter int BAT_TIMEOUT  = 40_000_000,
    parameter int MAX_RETRY    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [7:0] tx_data,
    output logic       wr_ps2,
    input  logic       tx_done_tick,
    input  logic [7:0] rx_data,
    input  logic       rx_done_tick,
    output logic       busy,
    output logic       stream_en,
    output logic       error,
    output logic       wheel_present,
    output logic [3:0] step
);

    localparam int TMAX = (BAT_TIMEOUT > RESP_TIMEOUT) ?
                          BAT_TIMEOUT : RESP_TIMEOUT;
    localparam int TW = $clog2(TMAX + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);

    state_t        state, state_nxt;
    logic [3:0]    step_q, step_nxt;
    logic [RW-1:0] retry_q, retry_nxt;
    logic [TW-1:0] timer_q, timer_load;
    logic          wheel_q, wheel_nxt;
    logic          expired;
    logic          advance, retry_req;
    rom_entry_t    rom;

    mouse_cmd_rom u_rom (
        .step  (step_q),
        .entry (rom)
    );

    assign expired = (timer_q == '0);

    // State, step/retry bookkeeping and the shared response timer
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            step_q  <= '0;
            retry_q <= '0;
            timer_q <= '0;
            wheel_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            step_q  <= step_nxt;
            retry_q <= retry_nxt;
            wheel_q <= wheel_nxt;
            if (state_nxt != state) begin
                timer_q <= timer_load;
            end else if (!expired) begin
                timer_q <= timer_q - 1'b1;
            end
        end
    end

    // Next-state: command progress, response checks and retry policy
    always_comb begin
        state_nxt = state;
        step_nxt  = step_q;
        retry_nxt = retry_q;
        wheel_nxt = wheel_q;
        advance   = 1'b0;
        retry_req = 1'b0;
        unique case (state)
            ST_IDLE, ST_STREAM, ST_FAIL: begin
                if (start) begin
                    state_nxt = ST_SEND;
                    step_nxt  = '0;
                    retry_nxt = '0;
                    wheel_nxt = 1'b0;
                end
            end
            ST_SEND: state_nxt = ST_WAIT_TX;
            ST_WAIT_TX: begin
                if (tx_done_tick) begin
                    state_nxt = ST_WAIT_ACK;
                end else if (expired) begin
                    retry_req = 1'b1;
                end
            end
            ST_WAIT_ACK: begin
                if (rx_done_tick) begin
                    if (rx_data != RSP_ACK) begin
                        retry_req = 1'b1;
                    end else if (step_q == 4'd0) begin
                        state_nxt = ST_WAIT_BAT;
                    end else if (rom.expect_id) begin
                        state_nxt = ST_WAIT_ID;
                    end else if (rom.last) begin
                        state_nxt = ST_STREAM;
                    end else begin
                        advance = 1'b1;
                    end
                end else if (expired) begin
                    retry_req = 1'b1;
                end
            end
            ST_WAIT_BAT: begin
                if (rx_done_tick) begin
                    if (rx_data == RSP_BAT_OK) begin
                        state_nxt = ST_WAIT_ID;
                    end else begin
                        retry_req = 1'b1;
                    end
                end else if (expired) begin
                    retry_req = 1'b1;
                end
            end
            ST_WAIT_ID: begin
                if (rx_done_tick) begin
`ifdef MOUSE_SEQ_WHEEL_EN
                    if (rom.expect_id) begin
                        wheel_nxt = (rx_data == ID_WHEEL);
                    end
`endif
                    if (rom.last) begin
                        state_nxt = ST_STREAM;
                    end else begin
                        advance = 1'b1;
                    end
                end else if (expired) begin
                    retry_req = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (advance) begin
            step_nxt  = step_q + 4'd1;
            retry_nxt = '0;
            state_nxt = ST_SEND;
        end
        if (retry_req) begin
            if (retry_q == RW'(MAX_RETRY)) begin
                state_nxt = ST_FAIL;
            end else begin
                retry_nxt = retry_q + 1'b1;
                state_nxt = ST_SEND;
            end
        end
        timer_load = (state_nxt == ST_WAIT_BAT) ?
                     TW'(BAT_TIMEOUT - 1) : TW'(RESP_TIMEOUT - 1);
    end

    // Outputs decoded from state; tx_data only driven alongside wr_ps2
    always_comb begin
        wr_ps2        = (state == ST_SEND);
        tx_data       = wr_ps2 ? rom.cmd : 8'h00;
        busy          = (state == ST_SEND) || is_wait(state);
        stream_en     = (state == ST_STREAM);
        error         = (state == ST_FAIL);
        wheel_present = wheel_q;
        step          = step_q;
    end

endmodule

// File: tb/tb_mouse_init_sequencer.sv
// Directed bench for mouse_init_sequencer with a hand-driven device model.
// Covers MOUSE_SEQ_WHEEL_EN builds as well as the default build.
module tb_mouse_init_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] tx_data;
    logic       wr_ps2;
    logic       tx_done_tick = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done_tick = 1'b0;
    logic       busy, stream_en, error, wheel_present;
    logic [3:0] step;

    int passed = 0;
    int total  = 0;

`ifdef MOUSE_SEQ_WHEEL_EN
    localparam logic [3:0] EN_STEP = 4'd8;
`else
    localparam logic [3:0] EN_STEP = 4'd1;
`endif

    mouse_init_sequencer #(
        .RESP_TIMEOUT (100),
        .BAT_TIMEOUT  (300),
        .MAX_RETRY    (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .tx_data       (tx_data),
        .wr_ps2        (wr_ps2),
        .tx_done_tick  (tx_done_tick),
        .rx_data       (rx_data),
        .rx_done_tick  (rx_done_tick),
        .busy          (busy),
        .stream_en     (stream_en),
        .error         (error),
        .wheel_present (wheel_present),
        .step          (step)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic wait_wr(input logic [7:0] exp, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (wr_ps2) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk({tag, "_wr"}, seen, 1'b1);
        chk({tag, "_byte"}, tx_data, exp);
    endtask

    task automatic send_cmd(input logic [7:0] exp, input string tag);
        wait_wr(exp, tag);
        tick();
        chk({tag, "_wr_one_cycle"}, wr_ps2, 1'b0);
        tx_done_tick = 1'b1;
        tick();
        tx_done_tick = 1'b0;
    endtask

    task automatic rx(input logic [7:0] b);
        rx_data      = b;
        rx_done_tick = 1'b1;
        tick();
        rx_done_tick = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic mid_steps();
`ifdef MOUSE_SEQ_WHEEL_EN
        send_cmd(8'hF3, "w_f3a"); rx(8'hFA);
        send_cmd(8'hC8, "w_c8");  rx(8'hFA);
        send_cmd(8'hF3, "w_f3b"); rx(8'hFA);
        send_cmd(8'h64, "w_64");  rx(8'hFA);
        send_cmd(8'hF3, "w_f3c"); rx(8'hFA);
        send_cmd(8'h50, "w_50");  rx(8'hFA);
        send_cmd(8'hF2, "w_f2");  rx(8'hFA);
        rx(8'h03);
`endif
    endtask

    task automatic full_seq(input string tag);
        send_cmd(8'hFF, {tag, "_ff"});
        rx(8'hFA); rx(8'hAA); rx(8'h00);
        mid_steps();
        send_cmd(8'hF4, {tag, "_f4"});
        rx(8'hFA);
        chk({tag, "_stream"}, stream_en, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_err"}, error, 1'b0);
    endtask

    initial begin
        int cnt;
        logic bad;

        // reset state
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_stream", stream_en, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_wr", wr_ps2, 1'b0);
        chk("rst_txdata", tx_data, 8'h00);
        chk("rst_step", step, 4'd0);
        chk("rst_wheel", wheel_present, 1'b0);

        // normal sequence, wr_ps2 on the cycle after start
        pulse_start();
        chk("s1_wr_next", wr_ps2, 1'b1);
        chk("s1_busy", busy, 1'b1);
        full_seq("s1");
`ifdef MOUSE_SEQ_WHEEL_EN
        chk("s1_wheel", wheel_present, 1'b1);
`else
        chk("s1_wheel", wheel_present, 1'b0);
`endif

        // restart from STREAM, start while busy, FE on enable
        pulse_start();
        chk("s2_stream_off", stream_en, 1'b0);
        chk("s2_wr", wr_ps2, 1'b1);
        chk("s2_ff", tx_data, 8'hFF);
        tick();
        pulse_start();
        chk("s2_busy_ign", busy, 1'b1);
        chk("s2_no_wr", wr_ps2, 1'b0);
        tx_done_tick = 1'b1;
        tick();
        tx_done_tick = 1'b0;
        rx(8'hFA); rx(8'hAA); rx(8'h00);
        mid_steps();
        send_cmd(8'hF4, "s2_f4a");
        rx(8'hFE);
        wait_wr(8'hF4, "s2_f4b");
        chk("s2_step", step, EN_STEP);
        tick();
        tx_done_tick = 1'b1;
        tick();
        tx_done_tick = 1'b0;
        rx(8'hFA);
        chk("s2_stream", stream_en, 1'b1);
        chk("s2_err", error, 1'b0);

        // silent device: FF four times then FAIL
        pulse_start();
        cnt = 0;
        bad = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (wr_ps2) begin
                cnt++;
                if (tx_data != 8'hFF) bad = 1'b1;
            end
            if (error) break;
            tick();
        end
        chk("s3_ff_count", cnt, 4);
        chk("s3_ff_bytes", bad, 1'b0);
        chk("s3_error", error, 1'b1);
        chk("s3_stream", stream_en, 1'b0);
        chk("s3_busy", busy, 1'b0);

        // rst while waiting for BAT, then clean run
        pulse_start();
        chk("s4_err_clr", error, 1'b0);
        send_cmd(8'hFF, "s4_ff");
        rx(8'hFA);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("s4_busy", busy, 1'b0);
        chk("s4_wr", wr_ps2, 1'b0);
        chk("s4_step", step, 4'd0);
        chk("s4_stream", stream_en, 1'b0);
        chk("s4_error", error, 1'b0);
        tick();
        pulse_start();
        full_seq("s5");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
